// File: rtl/cache_line_ram.sv
// Cache data array: byte-enable CPU word access with 1-cycle registered read, plus a
// beat-by-beat refill port that buffers a whole line and commits it in one cycle.
module cache_line_ram #(
    parameter int unsigned LINES  = 1024,
    parameter int unsigned WORDS  = 4,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned IW = $clog2(LINES),
    localparam int unsigned OW = $clog2(WORDS),
    localparam int unsigned BE = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [BE-1:0]     byte_en,
    input  logic [IW-1:0]     index,
    input  logic [OW-1:0]     offset,
    input  logic [DATA_W-1:0] data_in,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    input  logic              fill_start,
    input  logic [IW-1:0]     fill_index,
    input  logic              fill_valid,
    input  logic [DATA_W-1:0] fill_data,
    output logic              fill_ready,
    output logic              fill_busy,
    output logic              fill_done
);

    typedef enum logic [1:0] {StIdle, StFill, StCommit} fill_state_e;

    fill_state_e state_q, state_d;
    logic [OW-1:0] beat_q, beat_d;
    logic [IW-1:0] fill_idx_q;
    logic          fill_ready_q, fill_done_q;
    logic          rd_valid_q;
    logic [DATA_W-1:0] data_out_q;

    // Word 0 sits in the top slice of a line, so word k lives at packed slot WORDS-1-k,
    // which is simply the bitwise inverse of k for a power-of-two word count.
    logic [WORDS-1:0][BE-1:0][7:0] mem [LINES];
    logic [WORDS-1:0][BE-1:0][7:0] line_buf_q;

    logic          cpu_rd, cpu_wr, beat_acc, last_beat;
    logic [OW-1:0] cpu_slot, beat_slot;

    assign cpu_ready = (state_q != StCommit);
    assign fill_busy = (state_q != StIdle);
    assign cpu_rd    = rd_en & cpu_ready;
    assign cpu_wr    = wr_en & cpu_ready;
    assign beat_acc  = fill_valid & fill_ready_q;
    assign last_beat = (beat_q == OW'(WORDS - 1));
    assign cpu_slot  = ~offset;
    assign beat_slot = ~beat_q;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        unique case (state_q)
            StIdle: begin
                if (fill_start) begin
                    state_d = StFill;
                    beat_d  = '0;
                end
            end
            StFill: begin
                if (beat_acc) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) state_d = StCommit;
                end
            end
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= StIdle;
            beat_q       <= '0;
            fill_idx_q   <= '0;
            fill_ready_q <= 1'b0;
            fill_done_q  <= 1'b0;
            rd_valid_q   <= 1'b0;
            data_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            fill_ready_q <= (state_d == StFill);
            fill_done_q  <= (state_d == StCommit);
            rd_valid_q   <= cpu_rd;
            if (state_q == StIdle && fill_start) fill_idx_q <= fill_index;
            if (cpu_rd) data_out_q <= mem[index][cpu_slot];
        end
    end

    // Array and line buffer are never cleared; reset only blocks updates in that cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (beat_acc) line_buf_q[beat_slot] <= fill_data;
            if (state_q == StCommit) begin
                mem[fill_idx_q] <= line_buf_q;
            end else if (cpu_wr) begin
                for (int b = 0; b < int'(BE); b++) begin
                    if (byte_en[b]) mem[index][cpu_slot][b] <= data_in[8*b +: 8];
                end
            end
        end
    end

    assign fill_ready = fill_ready_q;
    assign fill_done  = fill_done_q;
    assign rd_valid   = rd_valid_q;
    assign data_out   = data_out_q;

endmodule
